// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state encoding and address-split width helpers shared by dcache_sa
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_e;
  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction
  function automatic int wsel_w(input int line_w, input int data_w);
    return $clog2(line_w / data_w);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - off_w(line_w) - idx_w(sets);
  endfunction
  function automatic int lru_w(input int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: per-set age array providing the replacement victim and LRU touch update
module dcache_lru import dcache_pkg::*; #(
  parameter int SETS = 32,
  parameter int WAYS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [idx_w(SETS)-1:0] idx_i,
  input  logic [WAYS-1:0]        valid_i,
  input  logic                   touch_i,
  input  logic [lru_w(WAYS)-1:0] touch_way_i,
  output logic [lru_w(WAYS)-1:0] victim_o
);
  localparam int AW = lru_w(WAYS);
  logic [AW-1:0] age_q [SETS][WAYS];
  logic [AW-1:0] row_d [WAYS];
  logic [AW-1:0] old_age, oldest_age;
  logic found;
  always_comb begin
    victim_o = '0;
    oldest_age = age_q[idx_i][0];
    found = 1'b0;
    for (int w = 1; w < WAYS; w++)
      if (age_q[idx_i][w] > oldest_age) begin
        victim_o = AW'(w);
        oldest_age = age_q[idx_i][w];
      end
    for (int w = 0; w < WAYS; w++)
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found = 1'b1;
      end
  end
  // <= rather than < so ways still sharing the reset age of 0 get pushed apart
  always_comb begin
    old_age = age_q[idx_i][touch_way_i];
    for (int w = 0; w < WAYS; w++)
      row_d[w] = AW'(w) == touch_way_i ? '0 :
                 (age_q[idx_i][w] <= old_age && age_q[idx_i][w] != AW'(WAYS - 1)) ? age_q[idx_i][w] + 1'b1 :
                 age_q[idx_i][w];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= '0;
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[idx_i][w] <= row_d[w];
    end
  end
endmodule

// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative write-back/write-allocate data cache with LRU and hit/miss counters
module dcache_sa import dcache_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int OFF_W  = off_w(LINE_W);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WAY_W  = lru_w(WAYS);
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] line_q  [SETS][WAYS];
  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d, hit_way, lru_victim;
  logic              mem_enable_q, mem_enable_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, req_line, victim_line;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  wsel;
  logic [WAYS-1:0]   set_valid;
  logic              hit, idle, acc_hit, acc_miss, wr_hit, fill;
  assign idx = p1_addr_i[OFF_W +: IDX_W];
  assign tag = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel = p1_addr_i[OFF_W-1:0] >> BYTE_W;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = valid_q[idx][w];
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end
  assign idle        = state_q == IDLE;
  assign acc_hit     = idle && (p1_MemRead_i || p1_MemWrite_i) && hit;
  assign acc_miss    = idle && (p1_MemRead_i || p1_MemWrite_i) && !hit;
  assign wr_hit      = acc_hit && p1_MemWrite_i;
  assign fill        = state_q == REFILL && mem_ack_i;
  assign req_line    = {tag, idx, {OFF_W{1'b0}}};
  assign victim_line = {tag_q[idx][lru_victim], idx, {OFF_W{1'b0}}};
  assign p1_stall_o  = !idle || acc_miss;
  assign p1_data_o   = acc_hit && !p1_MemWrite_i ? line_q[idx][hit_way][wsel * DATA_W +: DATA_W] : '0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
  assign hit_cnt_d    = hit_cnt_q + {31'b0, acc_hit && hit_cnt_q != '1};
  assign miss_cnt_d   = miss_cnt_q + {31'b0, acc_miss && miss_cnt_q != '1};
  dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_i     (set_valid),
    .touch_i     (acc_hit),
    .touch_way_i (hit_way),
    .victim_o    (lru_victim)
  );
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: if (acc_miss) begin
        victim_d     = lru_victim;
        mem_enable_d = 1'b1;
        mem_write_d  = valid_q[idx][lru_victim] && dirty_q[idx][lru_victim];
        mem_addr_d   = mem_write_d ? victim_line : req_line;
        mem_data_d   = line_q[idx][lru_victim];
        state_d      = mem_write_d ? WRITEBACK : REFILL;
      end
      WRITEBACK: if (mem_ack_i) begin
        state_d     = REFILL;
        mem_write_d = 1'b0;
        mem_addr_d  = req_line;
      end
      REFILL: if (mem_ack_i) begin
        state_d      = UPDATE;
        mem_enable_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
    end else begin
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[idx][hit_way] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx][victim_q]  <= tag;
      line_q[idx][victim_q] <= mem_data_i;
    end
    if (wr_hit) line_q[idx][hit_way][wsel * DATA_W +: DATA_W] <= p1_data_i;
  end
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed vector table, reset-abort sequence and random accesses against a recency-list cache model
module tb_dcache_sa;
  localparam int WAYS = 2;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  dcache_sa dut (
    .clk_i(clk), .rst_i(rst_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i), .p1_data_o(p1_data_o),
    .p1_stall_o(p1_stall_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic [255:0] back [int];
  logic [31:0]  refm [int];
  function automatic logic [255:0] line_of(input int la);
    logic [255:0] l;
    if (back.exists(la)) return back[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + w * 4) ^ 32'h5A5A_0000;
    return l;
  endfunction
  function automatic logic [31:0] ref_word(input int a);
    logic [255:0] l;
    if (refm.exists(a)) return refm[a];
    l = line_of(a & ~31);
    return l[(a & 31) * 8 +: 32];
  endfunction

  int lat = 0, cnt = 0, ack_cyc = 0;
  bit last_wr = 1'b0;
  int rf_q[$], wb_q[$];
  logic [255:0] wbd_q[$];
  always @(negedge clk) begin
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
      chk("en_after_ack", mem_enable_o, last_wr);
      if (last_wr) chk("write_after_wb_ack", mem_write_o, 0);
    end else if (mem_enable_o) begin
      if (cnt == lat) begin
        mem_ack_i = 1'b1;
        ack_cyc = cyc;
        last_wr = mem_write_o;
        if (mem_write_o) begin
          back[int'(mem_addr_o)] = mem_data_o;
          wb_q.push_back(int'(mem_addr_o));
          wbd_q.push_back(mem_data_o);
        end else begin
          mem_data_i = line_of(int'(mem_addr_o));
          rf_q.push_back(int'(mem_addr_o));
        end
      end else cnt++;
    end else cnt = 0;
  end

  // model: per set, tags in most-recent-first order with their dirty flags
  int mt[32][$];
  bit md[32][$];
  int hits_m = 0, miss_m = 0;

  task automatic model_reset();
    for (int s = 0; s < 32; s++) begin
      mt[s].delete();
      md[s].delete();
    end
    refm.delete();
    hits_m = 0;
    miss_m = 0;
  endtask

  task automatic access(input int a, input bit rd, input bit wr, input logic [31:0] d,
                        output bit miss, output logic [31:0] dout, output int wba, output logic [255:0] wbd);
    int s, t, pos, n, exp_wba;
    bit exp_miss, exp_wb, dirty;
    logic [31:0] exp_d;
    logic [255:0] exp_wbl;
    s = (a >> 5) & 31;
    t = a >> 10;
    pos = -1;
    exp_wb = 1'b0;
    exp_wba = 0;
    exp_wbl = '0;
    dirty = 1'b0;
    for (int i = 0; i < mt[s].size(); i++) if (mt[s][i] == t) pos = i;
    exp_miss = pos < 0;
    if (!exp_miss) begin
      dirty = md[s][pos];
      mt[s].delete(pos);
      md[s].delete(pos);
    end else if (mt[s].size() == WAYS) begin
      exp_wb = md[s][WAYS-1];
      exp_wba = (mt[s][WAYS-1] << 10) | (s << 5);
      for (int w = 0; w < 8; w++) exp_wbl[w*32 +: 32] = ref_word(exp_wba + w * 4);
      mt[s].delete(WAYS - 1);
      md[s].delete(WAYS - 1);
    end
    mt[s].push_front(t);
    md[s].push_front(dirty | wr);
    exp_d = (rd && !wr) ? ref_word(a) : 32'h0;
    if (wr) refm[a] = d;
    hits_m++;
    if (exp_miss) miss_m++;
    rf_q.delete();
    wb_q.delete();
    wbd_q.delete();
    @(negedge clk);
    p1_addr_i = a;
    p1_data_i = d;
    p1_MemRead_i = rd;
    p1_MemWrite_i = wr;
    #1;
    miss = p1_stall_o;
    n = 0;
    if (miss) chk("en_low_at_miss", mem_enable_o, 0);
    while (p1_stall_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      if (n == 1) chk("en_rise", mem_enable_o, 1);
    end
    if (p1_stall_o) chk("stall_timeout", p1_stall_o, 0);
    chk("miss", miss, exp_miss);
    if (miss) chk("stall_drop_after_ack", cyc - ack_cyc, 2);
    chk("rdata", p1_data_o, exp_d);
    dout = p1_data_o;
    chk("refill_count", rf_q.size(), exp_miss);
    if (rf_q.size() > 0) chk("refill_addr", rf_q[0], a & ~31);
    chk("wb_count", wb_q.size(), exp_wb);
    wba = -1;
    wbd = '0;
    if (wb_q.size() > 0) begin
      wba = wb_q[0];
      wbd = wbd_q[0];
      chk("wb_addr", wb_q[0], exp_wba);
      chk("wb_line", wbd_q[0], exp_wbl);
    end
    @(posedge clk);
    #1;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    chk("hit_cnt", hit_cnt_o, hits_m);
    chk("miss_cnt", miss_cnt_o, miss_m);
  endtask

  typedef struct {
    int a; bit rd; bit wr; logic [31:0] d; int lat;
    bit miss; logic [31:0] rdata; bit wb; int wba; logic [31:0] wb_w1;
  } vec_t;
  vec_t tbl[11];

  initial begin
    bit miss;
    logic [31:0] dout;
    int wba, n, a;
    logic [255:0] wbd, l;
    tbl[0]  = '{32'h040,  1, 0, 32'h0,         10, 1, 32'h1111_1111, 0, 0,      32'h0};
    tbl[1]  = '{32'h044,  0, 1, 32'hDEAD_BEEF, 0,  0, 32'h0,         0, 0,      32'h0};
    tbl[2]  = '{32'h044,  1, 0, 32'h0,         0,  0, 32'hDEAD_BEEF, 0, 0,      32'h0};
    tbl[3]  = '{32'h440,  1, 0, 32'h0,         3,  1, 32'h5A5A_0440, 0, 0,      32'h0};
    tbl[4]  = '{32'h840,  1, 0, 32'h0,         2,  1, 32'h5A5A_0840, 1, 32'h40, 32'hDEAD_BEEF};
    tbl[5]  = '{32'h040,  1, 0, 32'h0,         1,  1, 32'h1111_1111, 0, 0,      32'h0};
    tbl[6]  = '{32'h044,  1, 0, 32'h0,         0,  0, 32'hDEAD_BEEF, 0, 0,      32'h0};
    tbl[7]  = '{32'h048,  1, 1, 32'hCAFE_F00D, 0,  0, 32'h0,         0, 0,      32'h0};
    tbl[8]  = '{32'h048,  1, 0, 32'h0,         0,  0, 32'hCAFE_F00D, 0, 0,      32'h0};
    tbl[9]  = '{32'h3040, 1, 0, 32'h0,         0,  1, 32'h5A5A_3040, 0, 0,      32'h0};
    tbl[10] = '{32'h5040, 1, 0, 32'h0,         0,  1, 32'h5A5A_5040, 1, 32'h40, 32'hDEAD_BEEF};
    l = line_of(32'h40);
    l[31:0] = 32'h1111_1111;
    back[32'h40] = l;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    chk("rst_hits", hit_cnt_o, 0);
    chk("rst_misses", miss_cnt_o, 0);
    chk("rst_pdata", p1_data_o, 0);
    chk("rst_stall", p1_stall_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      lat = tbl[i].lat;
      access(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].d, miss, dout, wba, wbd);
      chk($sformatf("tbl%0d_miss", i), miss, tbl[i].miss);
      chk($sformatf("tbl%0d_rdata", i), dout, tbl[i].rdata);
      chk($sformatf("tbl%0d_wb_addr", i), wba, tbl[i].wb ? tbl[i].wba : -1);
      if (tbl[i].wb) chk($sformatf("tbl%0d_wb_word1", i), wbd[63:32], tbl[i].wb_w1);
    end
    lat = 0;
    access(32'h5044, 0, 1, 32'h7777_7777, miss, dout, wba, wbd);
    lat = 20;
    @(negedge clk);
    p1_addr_i = 32'h1000;
    p1_MemRead_i = 1'b1;
    n = 0;
    while (!mem_enable_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_en_high", mem_enable_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_enable", mem_enable_o, 0);
    chk("abort_stall", p1_stall_o, 0);
    chk("abort_hits", hit_cnt_o, 0);
    chk("abort_misses", miss_cnt_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    lat = 1;
    access(32'h040, 1, 0, 32'h0, miss, dout, wba, wbd);
    chk("reread_miss", miss, 1);
    access(32'h5044, 1, 0, 32'h0, miss, dout, wba, wbd);
    chk("discarded_dirty", dout, 32'h5A5A_5044);
    for (int i = 0; i < 300; i++) begin
      int op;
      a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      op = $urandom_range(0, 3);
      lat = $urandom_range(0, 3);
      access(a, op != 2, op >= 2, $urandom, miss, dout, wba, wbd);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
